// File: rtl/mac_filter.sv
// mac_filter: destination-address filter for the receive frame engine.
// A 14-entry exact-match table with per-entry valid bits is scanned one entry
// per clock after a fast-path check for promiscuous, broadcast and multicast.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a 0->1 transition of mac_rdy_i
// CHECK  | latched address; fast-path accept test
// SCAN   | comparing table entry r_idx against the latched address
// DONE   | result registered and held until mac_rdy_i falls
module mac_filter (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        mac_rdy_i,
   input  logic [47:0] mac_data_i,
   input  logic [1:0]  prmstp_i,
   input  logic        mcast_i,
   input  logic        tbl_we_i,
   input  logic [3:0]  tbl_addr_i,
   input  logic [47:0] tbl_data_i,
   input  logic        tbl_clr_i,
   output logic        cmp_done_o,
   output logic        cmp_res_o,
   output logic [3:0]  cmp_idx_o,
   output logic        busy_o
);

   localparam int          N_ENTRIES = 14;
   localparam logic [3:0]  LAST_IDX  = 4'd13;
   localparam logic [3:0]  IDX_NONE  = 4'hF;
   localparam logic [47:0] BCAST     = 48'hFFFF_FFFF_FFFF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CHECK = 2'd1,
      ST_SCAN  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [47:0]           r_tbl [N_ENTRIES];
   logic [N_ENTRIES-1:0]  r_vld;
   logic [47:0]           r_addr;
   logic [3:0]            r_idx;
   logic [3:0]            w_idx_nxt;
   logic                  r_rdy_was_low;
   logic                  r_done;
   logic                  r_res;
   logic [3:0]            r_res_idx;
   logic                  w_done_nxt;
   logic                  w_res_nxt;
   logic [3:0]            w_res_idx_nxt;
   logic                  w_latch;
   logic                  w_start;
   logic                  w_fast;
   logic                  w_hit;
   logic                  w_tbl_wr;

   // A new lookup starts only on a sampled 0->1 of mac_rdy_i. r_rdy_was_low
   // resets to 0 so a level still high when reset releases cannot start one.
   assign w_start  = mac_rdy_i & r_rdy_was_low;

   // Clear wins over a simultaneous write; indices 14 and 15 are dropped.
   assign w_tbl_wr = tbl_we_i & ~tbl_clr_i & (tbl_addr_i <= LAST_IDX);

   assign w_fast   = prmstp_i[1] | (r_addr == BCAST) | (mcast_i & r_addr[40]);

   // Compare the entry selected by r_idx using the table as it stands now.
   always_comb begin
      w_hit = 1'b0;
      for (int k = 0; k < N_ENTRIES; k++) begin
         if ((r_idx == 4'(k)) && r_vld[k] && (r_tbl[k] == r_addr)) begin
            w_hit = 1'b1;
         end
      end
   end

   // Table address storage; data needs no reset because valid bits gate it.
   always_ff @(posedge clk_i) begin
      for (int k = 0; k < N_ENTRIES; k++) begin
         if (w_tbl_wr && (tbl_addr_i == 4'(k))) begin
            r_tbl[k] <= tbl_data_i;
         end
      end
   end

   // Entry valid bits: cleared by reset or tbl_clr_i, set by a write.
   always_ff @(posedge clk_i) begin
      if (rst_i || tbl_clr_i) begin
         r_vld <= '0;
      end else begin
         for (int k = 0; k < N_ENTRIES; k++) begin
            if (w_tbl_wr && (tbl_addr_i == 4'(k))) begin
               r_vld[k] <= 1'b1;
            end
         end
      end
   end

   // mac_rdy_i edge detector.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rdy_was_low <= 1'b0;
      end else begin
         r_rdy_was_low <= ~mac_rdy_i;
      end
   end

   // Latch the destination address at the start of a lookup.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_addr <= '0;
      end else if (w_latch) begin
         r_addr <= mac_data_i;
      end
   end

   // State, scan index and registered result.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state   <= ST_IDLE;
         r_idx     <= '0;
         r_done    <= 1'b0;
         r_res     <= 1'b0;
         r_res_idx <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_idx     <= w_idx_nxt;
         r_done    <= w_done_nxt;
         r_res     <= w_res_nxt;
         r_res_idx <= w_res_idx_nxt;
      end
   end

   // Next-state and next-result decode.
   always_comb begin
      w_state_nxt   = r_state;
      w_idx_nxt     = r_idx;
      w_done_nxt    = r_done;
      w_res_nxt     = r_res;
      w_res_idx_nxt = r_res_idx;
      w_latch       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_start) begin
               w_latch     = 1'b1;
               w_state_nxt = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (!mac_rdy_i) begin
               w_state_nxt = ST_IDLE;
            end else if (w_fast) begin
               w_state_nxt   = ST_DONE;
               w_done_nxt    = 1'b1;
               w_res_nxt     = 1'b1;
               w_res_idx_nxt = IDX_NONE;
            end else begin
               w_state_nxt = ST_SCAN;
               w_idx_nxt   = '0;
            end
         end
         ST_SCAN: begin
            if (!mac_rdy_i) begin
               w_state_nxt = ST_IDLE;
            end else if (w_hit) begin
               w_state_nxt   = ST_DONE;
               w_done_nxt    = 1'b1;
               w_res_nxt     = 1'b1;
               w_res_idx_nxt = r_idx;
            end else if (r_idx == LAST_IDX) begin
               w_state_nxt   = ST_DONE;
               w_done_nxt    = 1'b1;
               w_res_nxt     = 1'b0;
               w_res_idx_nxt = IDX_NONE;
            end else begin
               w_idx_nxt = r_idx + 4'd1;
            end
         end
         ST_DONE: begin
            if (!mac_rdy_i) begin
               w_state_nxt   = ST_IDLE;
               w_done_nxt    = 1'b0;
               w_res_nxt     = 1'b0;
               w_res_idx_nxt = '0;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign cmp_done_o = r_done;
   assign cmp_res_o  = r_res;
   assign cmp_idx_o  = r_res_idx;
   assign busy_o     = (r_state == ST_CHECK) || (r_state == ST_SCAN);

endmodule

// File: tb/tb_mac_filter.sv
// tb_mac_filter: scoreboard bench for mac_filter. Each lookup pushes its
// expected result and latency; the entry is popped when cmp_done_o rises.
module tb_mac_filter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        mac_rdy_i;
   logic [47:0] mac_data_i;
   logic [1:0]  prmstp_i;
   logic        mcast_i;
   logic        tbl_we_i;
   logic [3:0]  tbl_addr_i;
   logic [47:0] tbl_data_i;
   logic        tbl_clr_i;
   logic        cmp_done_o;
   logic        cmp_res_o;
   logic [3:0]  cmp_idx_o;
   logic        busy_o;

   typedef struct {
      logic       res;
      logic [3:0] idx;
      int         lat;
   } exp_t;

   exp_t        sb_q [$];
   logic [47:0] m_tbl [14];
   logic [13:0] m_vld;
   int          n_cmp = 0;
   int          n_bad = 0;

   mac_filter dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .mac_rdy_i  (mac_rdy_i),
      .mac_data_i (mac_data_i),
      .prmstp_i   (prmstp_i),
      .mcast_i    (mcast_i),
      .tbl_we_i   (tbl_we_i),
      .tbl_addr_i (tbl_addr_i),
      .tbl_data_i (tbl_data_i),
      .tbl_clr_i  (tbl_clr_i),
      .cmp_done_o (cmp_done_o),
      .cmp_res_o  (cmp_res_o),
      .cmp_idx_o  (cmp_idx_o),
      .busy_o     (busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   function automatic exp_t model(input logic [47:0] a);
      exp_t e;
      e.res = 1'b0;
      e.idx = 4'hF;
      e.lat = 16;
      if (prmstp_i[1] || a == 48'hFFFF_FFFF_FFFF || (mcast_i && a[40])) begin
         e.res = 1'b1;
         e.lat = 2;
      end else begin
         for (int k = 13; k >= 0; k--) begin
            if (m_vld[k] && m_tbl[k] == a) begin
               e.res = 1'b1;
               e.idx = 4'(k);
               e.lat = 3 + k;
            end
         end
      end
      return e;
   endfunction

   task automatic tbl_wr(input logic [3:0] a, input logic [47:0] d, input logic clr);
      tbl_we_i   = 1'b1;
      tbl_addr_i = a;
      tbl_data_i = d;
      tbl_clr_i  = clr;
      tick();
      tbl_we_i  = 1'b0;
      tbl_clr_i = 1'b0;
      if (clr) m_vld = '0;
      else if (a <= 4'd13) begin
         m_tbl[a] = d;
         m_vld[a] = 1'b1;
      end
   endtask

   // wr_at > 0 drives a table write right after that edge count of the lookup.
   task automatic lookup(input string tag, input logic [47:0] a,
                         input int wr_at, input logic [3:0] wr_a, input logic [47:0] wr_d);
      exp_t e;
      int   n;
      bit   seen;
      if (wr_at > 0 && wr_a <= 4'd13) begin
         m_tbl[wr_a] = wr_d;
         m_vld[wr_a] = 1'b1;
      end
      sb_q.push_back(model(a));
      mac_data_i = a;
      mac_rdy_i  = 1'b1;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 40) begin
         tick();
         n++;
         tbl_we_i = 1'b0;
         if (n == wr_at) begin
            tbl_we_i   = 1'b1;
            tbl_addr_i = wr_a;
            tbl_data_i = wr_d;
         end
         if (cmp_done_o) seen = 1'b1;
      end
      tbl_we_i = 1'b0;
      e = sb_q.pop_front();
      if (!seen) begin
         chk({tag, "_timeout"}, 64'(cmp_done_o), 64'd1);
      end else begin
         chk({tag, "_lat"}, 64'(n), 64'(e.lat));
         chk({tag, "_res"}, 64'(cmp_res_o), 64'(e.res));
         chk({tag, "_idx"}, 64'(cmp_idx_o), 64'(e.idx));
         tick();
         chk({tag, "_hold"}, 64'({cmp_done_o, busy_o}), 64'b10);
      end
      mac_rdy_i = 1'b0;
      tick();
      chk({tag, "_clear"}, 64'({cmp_done_o, cmp_res_o, cmp_idx_o}), 64'd0);
   endtask

   initial begin
      int seen_done;
      rst_i = 1'b1; mac_rdy_i = 1'b0; mac_data_i = '0; prmstp_i = 2'b00;
      mcast_i = 1'b0; tbl_we_i = 1'b0; tbl_addr_i = '0; tbl_data_i = '0;
      tbl_clr_i = 1'b0; m_vld = '0;
      for (int k = 0; k < 14; k++) m_tbl[k] = '0;
      repeat (3) tick();
      chk("reset_out", 64'({cmp_done_o, cmp_res_o, cmp_idx_o, busy_o}), 64'd0);
      rst_i = 1'b0;
      tick();

      tbl_wr(4'd3, 48'h08002B112233, 1'b0);
      lookup("hit3", 48'h08002B112233, 0, 4'd0, '0);
      lookup("miss", 48'h08002B000001, 0, 4'd0, '0);
      lookup("bcast", 48'hFFFFFFFFFFFF, 0, 4'd0, '0);
      prmstp_i = 2'b10;
      lookup("prom", 48'h123456789ABC, 0, 4'd0, '0);
      prmstp_i = 2'b01;
      lookup("setup", 48'h08002B112233, 0, 4'd0, '0);
      prmstp_i = 2'b00;
      mcast_i = 1'b1;
      lookup("mc_on", 48'h01005E000001, 0, 4'd0, '0);
      mcast_i = 1'b0;
      lookup("mc_off", 48'h01005E000001, 0, 4'd0, '0);

      tbl_wr(4'd13, 48'hA1A2A3A4A5A6, 1'b0);
      lookup("hit13", 48'hA1A2A3A4A5A6, 0, 4'd0, '0);
      tbl_wr(4'd3, 48'h08002B112234, 1'b0);
      lookup("bit0", 48'h08002B112233, 0, 4'd0, '0);
      tbl_wr(4'd14, 48'h0A0B0C0D0E0F, 1'b0);
      lookup("addr14", 48'h0A0B0C0D0E0F, 0, 4'd0, '0);

      tbl_wr(4'd13, 48'h0000DEADBEEF, 1'b1);
      lookup("clr_we", 48'h0000DEADBEEF, 0, 4'd0, '0);
      lookup("clr_old", 48'hA1A2A3A4A5A6, 0, 4'd0, '0);
      lookup("zero", 48'h000000000000, 0, 4'd0, '0);

      lookup("scan_wr", 48'h02CAFE00BEEF, 3, 4'd10, 48'h02CAFE00BEEF);

      // Abort: mac_rdy_i sampled low at E5 while still scanning.
      tbl_wr(4'd5, 48'h02AABBCCDDEE, 1'b0);
      mac_data_i = 48'h02AABBCCDDEE;
      mac_rdy_i  = 1'b1;
      repeat (5) tick();
      chk("abort_busy_pre", 64'({busy_o, cmp_done_o}), 64'b10);
      mac_rdy_i = 1'b0;
      seen_done = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (cmp_done_o) seen_done++;
      end
      chk("abort_done", 64'(seen_done), 64'd0);
      chk("abort_busy", 64'(busy_o), 64'd0);

      // Reset while in DONE with mac_rdy_i held high.
      mac_data_i = 48'hFFFFFFFFFFFF;
      mac_rdy_i  = 1'b1;
      repeat (2) tick();
      chk("rst_pre_done", 64'(cmp_done_o), 64'd1);
      rst_i = 1'b1;
      tick();
      chk("rst_done_out", 64'({cmp_done_o, cmp_res_o, cmp_idx_o, busy_o}), 64'd0);
      rst_i = 1'b0;
      m_vld = '0;
      seen_done = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (cmp_done_o || busy_o) seen_done++;
      end
      chk("rst_no_retrig", 64'(seen_done), 64'd0);
      mac_rdy_i = 1'b0;
      tick();
      lookup("rst_vld", 48'h02AABBCCDDEE, 0, 4'd0, '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mac_filter.md
MAC_FILTER -- requirements
Module: mac_filter

Interface
REQ-001 The block SHALL have one clock and a synchronous active-high reset: clk_i and rst_i; no other clock or asynchronous input SHALL be used.
REQ-002 clk_i  in  1  receive-side clock, the same clock that drives the receive frame engine.
REQ-003 rst_i  in  1  synchronous active-high reset.
REQ-004 mac_rdy_i  in  1  destination address valid; a level held high until cmp_done_o is seen.
REQ-005 mac_data_i  in  48  destination MAC; [47:40] is the first received byte; mac_data_i[40] is the group (multicast) bit.
REQ-006 prmstp_i  in  2  [1] promiscuous (accept all); [0] setup mode (status only, no effect on the decision).
REQ-007 mcast_i  in  1  accept every multicast address.
REQ-008 tbl_we_i  in  1  table write strobe, one entry per cycle.
REQ-009 tbl_addr_i  in  4  table entry index; valid range 0..13.
REQ-010 tbl_data_i  in  48  table entry address, same byte order as mac_data_i.
REQ-011 tbl_clr_i  in  1  clears all entry valid bits.
REQ-012 cmp_done_o  out  1  comparison complete; held high until mac_rdy_i falls.
REQ-013 cmp_res_o  out  1  1 = accept frame, 0 = reject; meaningful only while cmp_done_o = 1.
REQ-014 cmp_idx_o  out  4  matching entry index; 4'hF = fast-path accept or reject.
REQ-015 busy_o  out  1  high in the CHECK and SCAN states.

Function
REQ-016 The table SHALL hold 14 entries of 48 bits, each with one valid bit.
REQ-017 A tbl_we_i write with tbl_addr_i <= 13 SHALL store tbl_data_i and set that entry's valid bit on the same edge; a write with tbl_addr_i of 14 or 15 SHALL be ignored.
REQ-018 tbl_clr_i SHALL clear all valid bits; when tbl_clr_i and tbl_we_i are both high, the clear SHALL take priority and the write SHALL be discarded.
REQ-019 The state machine SHALL have four states: IDLE, CHECK, SCAN, DONE.
REQ-020 IDLE: on the edge where mac_rdy_i = 1 and the previous sample was 0 (edge E0), the block SHALL latch mac_data_i and go to CHECK.
REQ-021 CHECK (edge E1): if prmstp_i[1] = 1, or the address is FF:FF:FF:FF:FF:FF, or (mcast_i = 1 and the group bit = 1), the block SHALL go to DONE with cmp_res_o = 1 and cmp_idx_o = F; otherwise it SHALL go to SCAN with index 0.
REQ-022 SCAN: at edge E(2+i) the block SHALL compare entry i. A valid entry equal to the latched address SHALL move the block to DONE with cmp_res_o = 1 and cmp_idx_o = i. No match at i = 13 SHALL move it to DONE with cmp_res_o = 0 and cmp_idx_o = F. Otherwise i SHALL increment.
REQ-023 Latency from E0 to cmp_done_o visible: fast path 2 edges; match at entry i takes 3+i edges; reject takes 16 edges.
REQ-024 DONE: cmp_done_o, cmp_res_o and cmp_idx_o SHALL be registered and stable; when mac_rdy_i = 0 is sampled, the block SHALL go to IDLE and clear cmp_done_o, cmp_res_o and cmp_idx_o to 0 on that edge.
REQ-025 mac_rdy_i falling in CHECK or SCAN SHALL abort to IDLE with no cmp_done_o assertion.
REQ-026 A table write during SCAN SHALL be allowed; the comparison SHALL use the table contents present at the edge on which each entry is compared.
REQ-027 The block SHALL detect a new address only on a 0->1 transition of mac_rdy_i; mac_rdy_i held high after DONE SHALL NOT retrigger.
REQ-028 Matching SHALL use all 48 bits exactly; an invalid entry SHALL never match, including an all-zero address.

Reset
REQ-029 On rst_i, the block SHALL enter IDLE; cmp_done_o, cmp_res_o and busy_o SHALL be 0, cmp_idx_o SHALL be 0, all valid bits SHALL be cleared, and the mac_rdy_i edge detector SHALL be cleared.
REQ-030 rst_i asserted during SCAN or DONE SHALL take effect on the same edge, overriding every other action; a mac_rdy_i still high after reset is released SHALL NOT start a comparison until it has been seen low.

Verification
REQ-031 Write entry 3 = 08:00:2B:11:22:33, raise mac_rdy_i with that address -> cmp_done_o after 6 edges, cmp_res_o = 1, cmp_idx_o = 3.
REQ-032 Empty table, mac_data_i = 08:00:2B:00:00:01 -> cmp_done_o after 16 edges, cmp_res_o = 0, cmp_idx_o = F; drop mac_rdy_i -> all outputs 0 on the next edge.
REQ-033 mac_data_i = FF:FF:FF:FF:FF:FF, and separately prmstp_i = 2'b10 with any address -> cmp_done_o after 2 edges, cmp_res_o = 1, cmp_idx_o = F.
REQ-034 mac_data_i = 01:00:5E:00:00:01: with mcast_i = 1 -> accept in 2 edges; with mcast_i = 0 and an empty table -> reject in 16 edges.
REQ-035 Start a scan, drop mac_rdy_i at E5 -> no cmp_done_o and busy_o = 0; separately assert rst_i in DONE -> outputs 0 and a held-high mac_rdy_i does not retrigger.
REQ-036 Write entry 13 with tbl_clr_i asserted on the same edge -> a later lookup of that address rejects.
